// File: rtl/hvgen_param.sv
// Parametrised video timing generator: pixel/line counters, blanking, sync and line/frame strobes.
// Signed screen offsets are latched at frame start so sync placement never tears inside a frame.
// Optional macro HVGEN_INTERLACE_EN adds field output F1 with alternating V_TOTAL / V_TOTAL+1 frames.
// Ports: MCLK, RESET_N (sync, active-low), CE (pixel enable), HOFFS/VOFFS (signed offsets),
//        iRGB (core pixel), HPOS/VPOS (counters), oRGB, HBLK, VBLK, HSYN/VSYN (active-low),
//        LSTART/FSTART (wrap strobes), F1 (interlace field, optional).
module hvgen_param #(
    parameter int CW           = 9,
    parameter int RGBW         = 8,
    parameter int H_TOTAL      = 456,
    parameter int H_ACTIVE     = 336,
    parameter int H_SYNC_START = 360,
    parameter int H_SYNC_W     = 24,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_W     = 3
) (
    input  logic            MCLK,
    input  logic            RESET_N,
    input  logic            CE,
    input  logic [4:0]      HOFFS,
    input  logic [2:0]      VOFFS,
    input  logic [RGBW-1:0] iRGB,
    output logic [CW-1:0]   HPOS,
    output logic [CW-1:0]   VPOS,
    output logic [RGBW-1:0] oRGB,
    output logic            HBLK,
    output logic            VBLK,
    output logic            HSYN,
    output logic            VSYN,
    output logic            LSTART,
`ifdef HVGEN_INTERLACE_EN
    output logic            FSTART,
    output logic            F1
`else
    output logic            FSTART
`endif
);

    if (H_ACTIVE + H_SYNC_W > H_TOTAL) begin : g_chk_h
        $error("hvgen_param: H_ACTIVE + H_SYNC_W exceeds H_TOTAL");
    end
    if (V_ACTIVE + V_SYNC_W > V_TOTAL) begin : g_chk_v
        $error("hvgen_param: V_ACTIVE + V_SYNC_W exceeds V_TOTAL");
    end
    if (H_TOTAL > (1 << CW)) begin : g_chk_cw
        $error("hvgen_param: H_TOTAL does not fit in CW bits");
    end

    // Sync placement arithmetic is signed, two bits wider than the counters.
    localparam int SW = CW + 2;
    typedef logic signed [SW-1:0] s_t;

    logic [CW-1:0]     hcnt;
    logic [CW-1:0]     vcnt;
    logic signed [4:0] hofs_l;
    logic signed [2:0] vofs_l;
    logic              h_wrap;
    logic              v_wrap;
    logic              f_wrap;
    logic              h_blank;
    logic              v_blank;
    logic              hs_act;
    logic              vs_act;
    s_t                hc_s;
    s_t                vc_s;
    s_t                hs_raw;
    s_t                hs_b;
    s_t                hs_e;
    s_t                vs_raw;
    s_t                vs_b;
    s_t                vs_e;

`ifdef HVGEN_INTERLACE_EN
    logic f1_q;
    logic half;

    // Odd fields carry one extra line.
    assign v_wrap = f1_q ? (vcnt == CW'(V_TOTAL)) : (vcnt == CW'(V_TOTAL - 1));
    assign F1     = f1_q;
    assign half   = (hc_s >= s_t'(H_TOTAL / 2));

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            f1_q <= 1'b0;
        end else if (CE && f_wrap) begin
            f1_q <= ~f1_q;
        end
    end

    // Odd fields move both VSYN edges to mid-line.
    always_comb begin
        if (f1_q) begin
            vs_act = ((vc_s > vs_b) || ((vc_s == vs_b) && half)) &&
                     ((vc_s < vs_e) || ((vc_s == vs_e) && !half));
        end else begin
            vs_act = (vc_s >= vs_b) && (vc_s < vs_e);
        end
    end
`else
    assign v_wrap = (vcnt == CW'(V_TOTAL - 1));
    assign vs_act = (vc_s >= vs_b) && (vc_s < vs_e);
`endif

    assign h_wrap = (hcnt == CW'(H_TOTAL - 1));
    assign f_wrap = h_wrap && v_wrap;

    assign HPOS = hcnt;
    assign VPOS = vcnt;

    assign LSTART = RESET_N && CE && h_wrap;
    assign FSTART = RESET_N && CE && f_wrap;

    assign hc_s = s_t'({2'b00, hcnt});
    assign vc_s = s_t'({2'b00, vcnt});

    assign hs_raw = s_t'(H_SYNC_START) + (s_t'(hofs_l) <<< 1);
    assign vs_raw = s_t'(V_SYNC_START) + (s_t'(vofs_l) <<< 1);

    // Clamp so the sync pulse stays wholly inside the blanking interval.
    always_comb begin
        hs_b = hs_raw;
        if (hs_raw < s_t'(H_ACTIVE)) begin
            hs_b = s_t'(H_ACTIVE);
        end else if (hs_raw > s_t'(H_TOTAL - H_SYNC_W)) begin
            hs_b = s_t'(H_TOTAL - H_SYNC_W);
        end
        vs_b = vs_raw;
        if (vs_raw < s_t'(V_ACTIVE)) begin
            vs_b = s_t'(V_ACTIVE);
        end else if (vs_raw > s_t'(V_TOTAL - V_SYNC_W)) begin
            vs_b = s_t'(V_TOTAL - V_SYNC_W);
        end
    end

    assign hs_e = hs_b + s_t'(H_SYNC_W);
    assign vs_e = vs_b + s_t'(V_SYNC_W);

    assign hs_act  = (hc_s >= hs_b) && (hc_s < hs_e);
    assign h_blank = (hcnt >= CW'(H_ACTIVE));
    assign v_blank = (vcnt >= CW'(V_ACTIVE));

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hofs_l <= '0;
            vofs_l <= '0;
        end else if (CE) begin
            if (h_wrap) begin
                hcnt <= '0;
                if (v_wrap) begin
                    vcnt   <= '0;
                    hofs_l <= $signed(HOFFS);
                    vofs_l <= $signed(VOFFS);
                end else begin
                    vcnt <= vcnt + CW'(1);
                end
            end else begin
                hcnt <= hcnt + CW'(1);
            end
        end
    end

    // Decoded from the pre-increment counters, so these lag HPOS/VPOS by one CE.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            HBLK <= 1'b1;
            VBLK <= 1'b1;
            HSYN <= 1'b1;
            VSYN <= 1'b1;
            oRGB <= '0;
        end else if (CE) begin
            HBLK <= h_blank;
            VBLK <= v_blank;
            HSYN <= ~hs_act;
            VSYN <= ~vs_act;
            oRGB <= (h_blank || v_blank) ? '0 : iRGB;
        end
    end

endmodule

// File: tb/tb_hvgen_param.sv
// Directed testbench for hvgen_param with a short frame (16 lines) to keep runs compact.
// Horizontal timing uses the production defaults.
module tb_hvgen_param;

    localparam int HT  = 456;
    localparam int HA  = 336;
    localparam int HSS = 360;
    localparam int HSW = 24;
    localparam int VT  = 16;
    localparam int VA  = 10;
    localparam int VSS = 10;
    localparam int VSW = 3;

    logic       MCLK = 1'b0;
    logic       RESET_N;
    logic       CE;
    logic [4:0] HOFFS;
    logic [2:0] VOFFS;
    logic [7:0] iRGB;
    logic [8:0] HPOS;
    logic [8:0] VPOS;
    logic [7:0] oRGB;
    logic       HBLK, VBLK, HSYN, VSYN, LSTART, FSTART;

    int   nc = 0;
    int   nf = 0;
    int   bh = 0;
    int   bv = 0;
    int   ls_cnt = 0;
    int   fs_cnt = 0;
    logic ls_s, fs_s;
    bit   rgb_ff = 1'b0;

    hvgen_param #(
        .CW(9), .RGBW(8),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .CE(CE),
        .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
        .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
        .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
        .LSTART(LSTART), .FSTART(FSTART)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit ce);
        CE = ce;
        #1;
        ls_s = LSTART;
        fs_s = FSTART;
        @(posedge MCLK);
        if (ce && RESET_N) begin
            if (bh == HT - 1) begin
                bh = 0;
                bv = (bv == VT - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
        @(negedge MCLK);
    endtask

    // Runs n CEs with gap idle cycles after each, checking every cycle.
    task automatic scan(input int n, input int gap, input int hsb, input int vsb);
        int         ph, pv;
        logic [7:0] rgb, e_rgb;
        logic       e_hb, e_vb, e_hs, e_vs, e_ls, e_fs;
        for (int k = 0; k < n; k++) begin
            ph    = bh;
            pv    = bv;
            rgb   = rgb_ff ? 8'hFF : 8'(ph ^ (pv << 4) ^ 8'h5A);
            e_hb  = (ph >= HA);
            e_vb  = (pv >= VA);
            e_hs  = !(ph >= hsb && ph < hsb + HSW);
            e_vs  = !(pv >= vsb && pv < vsb + VSW);
            e_rgb = (e_hb || e_vb) ? 8'h00 : rgb;
            for (int g = 0; g <= gap; g++) begin
                if (g == 0) begin
                    iRGB = rgb;
                    step(1'b1);
                    e_ls = (ph == HT - 1);
                    e_fs = e_ls && (pv == VT - 1);
                end else begin
                    iRGB = 8'($urandom);
                    step(1'b0);
                    e_ls = 1'b0;
                    e_fs = 1'b0;
                end
                if (ls_s === 1'b1) ls_cnt++;
                if (fs_s === 1'b1) fs_cnt++;
                nc++;
                if (HPOS !== 9'(bh) || VPOS !== 9'(bv) || HBLK !== e_hb ||
                    VBLK !== e_vb || HSYN !== e_hs || VSYN !== e_vs ||
                    oRGB !== e_rgb || ls_s !== e_ls || fs_s !== e_fs) begin
                    nf++;
                    if (nf <= 20)
                        $display("FAIL scan at h=%0d v=%0d g=%0d: got pos=%0d,%0d blk=%b%b syn=%b%b rgb=%h st=%b%b, want pos=%0d,%0d blk=%b%b syn=%b%b rgb=%h st=%b%b",
                                 ph, pv, g, HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, oRGB, ls_s, fs_s,
                                 bh, bv, e_hb, e_vb, e_hs, e_vs, e_rgb, e_ls, e_fs);
                end
            end
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        step(1'b0);
        step(1'b1);
        bh = 0;
        bv = 0;
        nc++;
        if (HPOS !== 9'd0 || VPOS !== 9'd0) begin
            nf++;
            $display("FAIL reset_pos: got %0d,%0d want 0,0", HPOS, VPOS);
        end
        nc++;
        if (HBLK !== 1'b1 || VBLK !== 1'b1 || HSYN !== 1'b1 || VSYN !== 1'b1) begin
            nf++;
            $display("FAIL reset_blk_syn: got %b%b%b%b want 1111", HBLK, VBLK, HSYN, VSYN);
        end
        nc++;
        if (oRGB !== 8'h00 || ls_s !== 1'b0 || fs_s !== 1'b0) begin
            nf++;
            $display("FAIL reset_rgb_strobe: got %h %b%b want 00 00", oRGB, ls_s, fs_s);
        end
        RESET_N = 1'b1;
        iRGB    = 8'h5A;
        step(1'b1);
        nc++;
        if (HPOS !== 9'd1 || VPOS !== 9'd0 || fs_s !== 1'b0 || HBLK !== 1'b0) begin
            nf++;
            $display("FAIL reset_release: got pos=%0d,%0d fs=%b hblk=%b want 1,0 0 0",
                     HPOS, VPOS, fs_s, HBLK);
        end
    endtask

    // First frame: CE every other MCLK for two lines, offsets changed mid-frame.
    task automatic test_frame_and_offset_change;
        int f0, l0;
        f0 = fs_cnt;
        l0 = ls_cnt;
        scan(911, 1, HSS, VSS);
        scan(HT * 3, 0, HSS, VSS);
        HOFFS = 5'b10000;
        VOFFS = 3'b100;
        scan(HT * 11, 0, HSS, VSS);
        nc++;
        if (fs_cnt - f0 !== 1) begin
            nf++;
            $display("FAIL frame_fstart_count: got %0d want 1", fs_cnt - f0);
        end
        nc++;
        if (ls_cnt - l0 !== VT) begin
            nf++;
            $display("FAIL frame_lstart_count: got %0d want %0d", ls_cnt - l0, VT);
        end
    endtask

    // HOFFS=-16, VOFFS=-4 clamp to the active edge.
    task automatic test_clamp_low;
        int f0;
        f0 = fs_cnt;
        scan(HT * 5, 0, HA, VA);
        HOFFS = 5'b01111;
        VOFFS = 3'b011;
        scan(HT * 11, 0, HA, VA);
        nc++;
        if (fs_cnt - f0 !== 1) begin
            nf++;
            $display("FAIL clamp_low_fstart: got %0d want 1", fs_cnt - f0);
        end
    endtask

    // HOFFS=+15 -> 390 unclamped; VOFFS=+3 -> 16 clamped to VT-VSW=13.
    task automatic test_clamp_high;
        scan(HT * 7, 0, 390, VT - VSW);
        HOFFS = 5'd5;
        VOFFS = 3'd1;
        scan(HT * 9, 0, 390, VT - VSW);
    endtask

    // HOFFS=+5 -> 370, VOFFS=+1 -> 12; CE held low across the active/blank edge.
    task automatic test_ce_hold;
        rgb_ff = 1'b1;
        scan(330, 0, 370, 12);
        scan(10, 10, 370, 12);
        scan(HT * VT - 340, 0, 370, 12);
        rgb_ff = 1'b0;
    endtask

    task automatic test_reset_mid;
        int f0;
        scan(HT * 7 + 100, 0, 370, 12);
        nc++;
        if (HBLK !== 1'b0 || VBLK !== 1'b0) begin
            nf++;
            $display("FAIL mid_pre_reset: got blk=%b%b want 00", HBLK, VBLK);
        end
        RESET_N = 1'b0;
        iRGB    = 8'h77;
        step(1'b1);
        bh = 0;
        bv = 0;
        nc++;
        if (HPOS !== 9'd0 || VPOS !== 9'd0 || HBLK !== 1'b1 || VBLK !== 1'b1 ||
            HSYN !== 1'b1 || VSYN !== 1'b1 || oRGB !== 8'h00) begin
            nf++;
            $display("FAIL mid_reset: got pos=%0d,%0d blk=%b%b syn=%b%b rgb=%h want 0,0 11 11 00",
                     HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, oRGB);
        end
        RESET_N = 1'b1;
        iRGB    = 8'h5A;
        step(1'b1);
        nc++;
        if (HPOS !== 9'd1 || VPOS !== 9'd0 || fs_s !== 1'b0) begin
            nf++;
            $display("FAIL mid_release: got pos=%0d,%0d fs=%b want 1,0 0", HPOS, VPOS, fs_s);
        end
        f0 = fs_cnt;
        scan(HT * VT - 1, 0, HSS, VSS);
        nc++;
        if (fs_cnt - f0 !== 1 || fs_s !== 1'b1) begin
            nf++;
            $display("FAIL mid_next_fstart: got count=%0d last=%b want 1 1", fs_cnt - f0, fs_s);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        CE      = 1'b0;
        HOFFS   = 5'd0;
        VOFFS   = 3'd0;
        iRGB    = 8'h00;
        @(negedge MCLK);
        test_reset;
        test_frame_and_offset_change;
        test_clamp_low;
        test_clamp_high;
        test_ce_hold;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
